// File: rtl/l2_cache_ctrl_nway_pkg.sv
// Package: l2_cache_ctrl_nway_pkg
// Purpose: shared types and constants for the N-way L2 cache controller.
//   l2_state_t         controller FSM states (SWEEP is the reset state)
//   DATA_SRC_*         data_src encodings for the data-array write mux
//   ADDR_SEL_*         pmem_addr_sel encodings for the pmem address mux
//   is_busy_state()    true for every state except IDLE
package l2_cache_ctrl_nway_pkg;

  typedef enum logic [2:0] {
    SWEEP     = 3'd0,
    IDLE      = 3'd1,
    LOOKUP    = 3'd2,
    WRITEBACK = 3'd3,
    ALLOCATE  = 3'd4
  } l2_state_t;

  localparam logic DATA_SRC_CPU    = 1'b0;
  localparam logic DATA_SRC_PMEM   = 1'b1;
  localparam logic ADDR_SEL_REQ    = 1'b0;
  localparam logic ADDR_SEL_VICTIM = 1'b1;

  function automatic logic is_busy_state(l2_state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/l2_cache_ctrl_nway_if.sv
// Interface: l2_cache_ctrl_nway_if
// Purpose: groups the upstream request handshake and the pmem handshake
// of the L2 controller.
//   mem_read / mem_write  upstream request, held until mem_resp
//   set_idx               set index of the current request
//   mem_resp              request done, 1-cycle pulse
//   pmem_read/pmem_write  line fill / line writeback request
//   pmem_addr_sel         0: request tag/index, 1: victim tag/index
//   pmem_resp             pmem transfer complete, 1-cycle pulse
// Modports:
//   master  the environment side (arbiter + physical memory)
//   slave   the controller side
interface l2_cache_ctrl_nway_if #(
  parameter int SET_BITS = 4
);

  logic                mem_read;
  logic                mem_write;
  logic [SET_BITS-1:0] set_idx;
  logic                mem_resp;
  logic                pmem_read;
  logic                pmem_write;
  logic                pmem_addr_sel;
  logic                pmem_resp;

  modport master (
    output mem_read, mem_write, set_idx, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel
  );

  modport slave (
    input  mem_read, mem_write, set_idx, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel
  );

endinterface

// File: rtl/l2_cache_ctrl_nway_plru.sv
// Module: l2_cache_ctrl_nway_plru
// Purpose: combinational tree-PLRU helper for one set.
//   bits       in   WAYS-1     current PLRU tree bits (heap order, node 0 = root)
//   way        in   WAY_BITS   way that was just accessed
//   victim     out  WAY_BITS   way the tree currently points at
//   bits_next  out  WAYS-1     tree bits after an access to 'way'
// A node bit of 0 steers the victim search towards the lower-index half,
// 1 towards the upper half. An access flips every node on its path to point
// away from the accessed way.
module l2_cache_ctrl_nway_plru #(
  parameter int WAYS = 4,
  localparam int WAY_BITS  = $clog2(WAYS),
  localparam int PLRU_BITS = WAYS - 1
) (
  input  logic [PLRU_BITS-1:0] bits,
  input  logic [WAY_BITS-1:0]  way,
  output logic [WAY_BITS-1:0]  victim,
  output logic [PLRU_BITS-1:0] bits_next
);

  // Walk root to leaf following the stored bits; the path spells the victim
  // index MSB first. Node numbers never exceed WAYS-2, so WAY_BITS is enough;
  // the value computed after the last level is never used.
  always_comb begin
    logic [WAY_BITS-1:0] node;
    victim = '0;
    node   = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      victim[WAY_BITS-1-l] = bits[node];
      node = (node << 1) + WAY_BITS'(1) + WAY_BITS'(bits[node]);
    end
  end

  // Walk the path of the accessed way and point each node at the other half.
  always_comb begin
    logic [WAY_BITS-1:0] node;
    logic                dir;
    bits_next = bits;
    node      = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      dir             = way[WAY_BITS-1-l];
      bits_next[node] = ~dir;
      node = (node << 1) + WAY_BITS'(1) + WAY_BITS'(dir);
    end
  end

endmodule

// File: rtl/l2_cache_ctrl_nway.sv
// Module: l2_cache_ctrl_nway
// Purpose: N-way write-back / write-allocate L2 cache control FSM. Drives the
// tag/valid/dirty/data array enables of the datapath and the pmem handshake,
// with per-set tree-PLRU replacement, invalid-first victim choice and a
// post-reset sweep that clears the valid bits of every set.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          request + pmem handshake (slave modport)
//   hit_vec      per-way tag match AND valid
//   valid_vec    valid bits of set_idx
//   dirty_vec    dirty bits of set_idx
//   array_idx    index to all arrays (sweep counter during SWEEP)
//   load_tag     one-hot tag-array write enable
//   load_valid   valid-array write enable, valid_in its data
//   load_dirty   dirty-array write enable, dirty_in its data
//   data_we      one-hot data-array write enable
//   data_src     0: CPU write data, 1: pmem fill line
//   busy         high in every state except IDLE
module l2_cache_ctrl_nway
  import l2_cache_ctrl_nway_pkg::*;
#(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  l2_cache_ctrl_nway_if.slave bus,
  input  logic [WAYS-1:0]     hit_vec,
  input  logic [WAYS-1:0]     valid_vec,
  input  logic [WAYS-1:0]     dirty_vec,
  output logic [SET_BITS-1:0] array_idx,
  output logic [WAYS-1:0]     load_tag,
  output logic [WAYS-1:0]     load_valid,
  output logic                valid_in,
  output logic [WAYS-1:0]     load_dirty,
  output logic                dirty_in,
  output logic [WAYS-1:0]     data_we,
  output logic                data_src,
  output logic                busy
);

  localparam int NUM_SETS  = 2 ** SET_BITS;
  localparam int WAY_BITS  = $clog2(WAYS);
  localparam int PLRU_BITS = WAYS - 1;

  l2_state_t            state;
  logic [SET_BITS-1:0]  sweep_cnt;
  logic [WAY_BITS-1:0]  victim;
  logic [PLRU_BITS-1:0] plru [NUM_SETS];

  logic                 is_hit;
  logic                 is_write;
  logic [WAY_BITS-1:0]  hit_way;
  logic                 any_invalid;
  logic [WAY_BITS-1:0]  invalid_way;
  logic [PLRU_BITS-1:0] plru_cur;
  logic [PLRU_BITS-1:0] plru_next;
  logic [WAY_BITS-1:0]  plru_victim;
  logic [WAY_BITS-1:0]  miss_victim;
  logic [WAYS-1:0]      victim_oh;

  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_addr_sel;

  assign is_hit      = |hit_vec;
  assign is_write    = bus.mem_write;
  assign any_invalid = ~&valid_vec;
  assign plru_cur    = plru[bus.set_idx];
  assign miss_victim = any_invalid ? invalid_way : plru_victim;
  assign victim_oh   = {{(WAYS-1){1'b0}}, 1'b1} << victim;

  // Lowest-index matching way; the datapath guarantees at most one hit.
  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_BITS'(w);
    end
  end

  // Lowest-index invalid way, preferred over the PLRU choice on a miss.
  always_comb begin
    invalid_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_vec[w]) invalid_way = WAY_BITS'(w);
    end
  end

  l2_cache_ctrl_nway_plru #(
    .WAYS (WAYS)
  ) u_plru (
    .bits      (plru_cur),
    .way       (hit_way),
    .victim    (plru_victim),
    .bits_next (plru_next)
  );

  // State, sweep counter, victim register and PLRU array. The victim is
  // captured once in LOOKUP so that WRITEBACK and ALLOCATE act on the same
  // way regardless of what the datapath presents meanwhile. PLRU only moves
  // on hits; a fill is followed by a re-lookup that hits and updates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SWEEP;
      sweep_cnt <= '0;
      victim    <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        plru[s] <= '0;
      end
    end else begin
      case (state)
        SWEEP: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (&sweep_cnt) state <= IDLE;
        end
        IDLE: begin
          if (bus.mem_read || bus.mem_write) state <= LOOKUP;
        end
        LOOKUP: begin
          if (is_hit) begin
            plru[bus.set_idx] <= plru_next;
            state             <= IDLE;
          end else begin
            victim <= miss_victim;
            state  <= dirty_vec[miss_victim] ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) state <= ALLOCATE;
        end
        ALLOCATE: begin
          if (bus.pmem_resp) state <= LOOKUP;
        end
        default: state <= SWEEP;
      endcase
    end
  end

  // Output decode. Hit and fill enables depend on same-cycle datapath and
  // pmem inputs, so they are decoded combinationally from the state. While
  // rst_n is low every output is forced to 0 so pmem requests drop at once.
  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = ADDR_SEL_REQ;
    array_idx     = bus.set_idx;
    load_tag      = '0;
    load_valid    = '0;
    valid_in      = 1'b0;
    load_dirty    = '0;
    dirty_in      = 1'b0;
    data_we       = '0;
    data_src      = DATA_SRC_CPU;
    busy          = is_busy_state(state);
    if (!rst_n) begin
      array_idx = '0;
      busy      = 1'b0;
    end else begin
      case (state)
        SWEEP: begin
          array_idx  = sweep_cnt;
          load_valid = '1;
          valid_in   = 1'b0;
        end
        LOOKUP: begin
          if (is_hit) begin
            mem_resp = 1'b1;
            if (is_write) begin
              data_we    = hit_vec;
              data_src   = DATA_SRC_CPU;
              load_dirty = hit_vec;
              dirty_in   = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = ADDR_SEL_VICTIM;
        end
        ALLOCATE: begin
          pmem_read     = 1'b1;
          pmem_addr_sel = ADDR_SEL_REQ;
          if (bus.pmem_resp) begin
            load_tag   = victim_oh;
            load_valid = victim_oh;
            valid_in   = 1'b1;
            load_dirty = victim_oh;
            dirty_in   = 1'b0;
            data_we    = victim_oh;
            data_src   = DATA_SRC_PMEM;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_resp      = mem_resp;
  assign bus.pmem_read     = pmem_read;
  assign bus.pmem_write    = pmem_write;
  assign bus.pmem_addr_sel = pmem_addr_sel;

endmodule
